sequential_divider: RTL and testbench

Unsigned restoring divider that computes one quotient bit per clock over WIDTH cycles, with the same start/ready handshake as the team's sequential multiplier. It is the inverse of shift-and-add multiplication. It pairs with the multiplier in the arithmetic unit so that software-visible mul and div share one issue/complete protocol. Its control FSM and its A/Q/M datapath are split the same way as in the multiplier.

---
 rtl/divider_pkg.sv | 12 +
 rtl/sequential_divider_if.sv | 22 ++
 rtl/sequential_divider_datapath.sv | 61 ++++++
 rtl/sequential_divider.sv | 66 ++++++
 tb/tb_sequential_divider.sv | 134 +++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divider_pkg;

    localparam int DIV_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WORKING = 2'd1,
        DONE    = 2'd2
    } div_state_t;

endpackage

// File: rtl/sequential_divider_if.sv
// Start/ready handshake bundle shared by the arithmetic unit and the divider.
interface sequential_divider_if #(parameter int WIDTH = 8);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             divide_by_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, quotient, remainder, divide_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, quotient, remainder, divide_by_zero
    );

endinterface

// File: rtl/sequential_divider_datapath.sv
// A/Q/M registers, trial subtractor and restore mux of the restoring divider.
module divider_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_do_init,
    input  logic             i_do_shift,
    input  logic             i_do_load_dbz,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_divide_by_zero
);

    // A's top bit is always 0 between iterations (A < M), so only its low
    // WIDTH bits are stored; the shift and trial subtract run WIDTH+1 wide.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic             r_dbz;

    logic [WIDTH:0] w_a_shifted;
    logic [WIDTH:0] w_trial;

    assign w_a_shifted = {r_a, r_q[WIDTH-1]};
    assign w_trial     = w_a_shifted - {1'b0, r_m};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a   <= '0;
            r_q   <= '0;
            r_m   <= '0;
            r_dbz <= 1'b0;
        end else if (i_do_init) begin
            r_m   <= i_divisor;
            r_dbz <= i_do_load_dbz;
            if (i_do_load_dbz) begin
                r_a <= i_dividend;
                r_q <= '1;
            end else begin
                r_a <= '0;
                r_q <= i_dividend;
            end
        end else if (i_do_shift) begin
            if (!w_trial[WIDTH]) begin
                r_a <= w_trial[WIDTH-1:0];
                r_q <= {r_q[WIDTH-2:0], 1'b1};
            end else begin
                r_a <= w_a_shifted[WIDTH-1:0];
                r_q <= {r_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign o_quotient       = r_q;
    assign o_remainder      = r_a;
    assign o_divide_by_zero = r_dbz;

endmodule

// File: rtl/sequential_divider.sv
// Unsigned restoring divider: control FSM and iteration counter; one quotient bit per clock.
module sequential_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic               clock,
    input  logic               reset_n,
    sequential_divider_if.slave bus
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;

    logic w_do_init;
    logic w_do_shift;
    logic w_do_load_dbz;

    // Operands are only looked at while not iterating, so mid-op changes are inert.
    assign w_do_init     = (r_state != WORKING) && bus.start;
    assign w_do_load_dbz = w_do_init && (bus.divisor == '0);
    assign w_do_shift    = (r_state == WORKING);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_do_init) begin
                        r_cnt   <= CNT_LAST;
                        r_state <= w_do_load_dbz ? DONE : WORKING;
                    end
                end
                WORKING: begin
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ready = (r_state == DONE);

    divider_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clock            (clock),
        .reset_n          (reset_n),
        .i_do_init        (w_do_init),
        .i_do_shift       (w_do_shift),
        .i_do_load_dbz    (w_do_load_dbz),
        .i_dividend       (bus.dividend),
        .i_divisor        (bus.divisor),
        .o_quotient       (bus.quotient),
        .o_remainder      (bus.remainder),
        .o_divide_by_zero (bus.divide_by_zero)
    );

endmodule

// File: tb/tb_sequential_divider.sv
// Directed and swept checks of sequential_divider at WIDTH=8.
module tb_sequential_divider;
    import divider_pkg::*;

    logic clock;
    logic reset_n;
    int   n_chk;
    int   n_bad;

    sequential_divider_if #(.WIDTH(8)) bus ();

    sequential_divider #(.WIDTH(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; start is driven for exactly the current cycle.
    task automatic run_op(input string tag, input int a, input int b,
                          input int eq, input int er, input int edz, input int elat);
        int n;
        n = 0;
        bus.start    = 1'b1;
        bus.dividend = 8'(a);
        bus.divisor  = 8'(b);
        do begin
            @(negedge clock);
            n++;
            bus.start = 1'b0;
            if (n == 1 && elat > 1) chk({tag, "_drop"}, 32'(bus.ready), 32'd0);
        end while (!bus.ready && n < 40);
        chk({tag, "_lat"}, 32'(n), 32'(elat));
        chk({tag, "_q"}, 32'(bus.quotient), 32'(eq));
        chk({tag, "_r"}, 32'(bus.remainder), 32'(er));
        chk({tag, "_dbz"}, 32'(bus.divide_by_zero), 32'(edz));
    endtask

    initial begin
        int n;
        int a;
        int b;
        n_chk = 0;
        n_bad = 0;
        reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst_ready", 32'(bus.ready), 32'd0);
        chk("rst_q", 32'(bus.quotient), 32'd0);
        chk("rst_r", 32'(bus.remainder), 32'd0);
        chk("rst_dbz", 32'(bus.divide_by_zero), 32'd0);

        run_op("d100_7", 100, 7, 14, 2, 0, 9);
        run_op("d255_1", 255, 1, 255, 0, 0, 9);
        run_op("d5_9", 5, 9, 0, 5, 0, 9);
        run_op("d200_200", 200, 200, 1, 0, 0, 9);

        // result must hold while DONE persists
        repeat (3) @(negedge clock);
        chk("hold_ready", 32'(bus.ready), 32'd1);
        chk("hold_q", 32'(bus.quotient), 32'd1);
        chk("hold_r", 32'(bus.remainder), 32'd0);

        run_op("d13_0", 13, 0, 255, 13, 1, 1);
        run_op("d13_2", 13, 2, 6, 1, 0, 9);

        // operand and start noise during WORKING
        n = 0;
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        do begin
            @(negedge clock);
            n++;
            if (!bus.ready && n <= 8) begin
                bus.start    = 1'($urandom_range(0, 1));
                bus.dividend = 8'($urandom_range(0, 255));
                bus.divisor  = 8'($urandom_range(0, 255));
            end
        end while (!bus.ready && n < 40);
        bus.start = 1'b0;
        chk("noise_lat", 32'(n), 32'd9);
        chk("noise_q", 32'(bus.quotient), 32'd14);
        chk("noise_r", 32'(bus.remainder), 32'd2);

        // reset mid-operation
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus.ready), 32'd0);
        chk("mid_rst_q", 32'(bus.quotient), 32'd0);
        chk("mid_rst_r", 32'(bus.remainder), 32'd0);
        chk("mid_rst_dbz", 32'(bus.divide_by_zero), 32'd0);
        chk("mid_rst_state", 32'(dut.r_state), 32'(IDLE));
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_rst_state", 32'(dut.r_state), 32'(IDLE));
        run_op("d50_6", 50, 6, 8, 2, 0, 9);

        // back-to-back: start re-asserted in the first DONE cycle
        run_op("d9_4", 9, 4, 2, 1, 0, 9);

        for (int i = 0; i < 20; i++) begin
            a = int'($urandom_range(0, 255));
            b = (i % 7 == 3) ? 0 : int'($urandom_range(0, 255));
            if (b == 0) run_op("sweep", a, b, 255, a, 1, 1);
            else        run_op("sweep", a, b, a / b, a % b, 0, 9);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
